y_sram_port: RTL and testbench

Responder end of the Y SRAM bus: consumes the single arbitrated stream of two read addresses plus one write port driven by the Y bus arbiter and services it against a 1-write/2-read Y data store. It provides registered read data with valid flags, a write acknowledge, and write-first forwarding on same-cycle address collisions. After reset it also zero-fills the whole array before accepting traffic. It sits directly below the bus arbiter and is the only block that owns Y storage.

---
 rtl/y_sram_pkg.sv | 17 +
 rtl/y_sram_array.sv | 32 +++
 rtl/y_sram_port.sv | 138 +++++++++++++
 tb/tb_y_sram_port.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/y_sram_pkg.sv
// Shared Y SRAM constants and state encoding, used by the bus arbiter and the
// Y storage port.
package y_sram_pkg;

    localparam int unsigned Y_ADDR_W = 11;
    localparam int unsigned Y_DATA_W = 256;
    localparam int unsigned Y_DEPTH  = 1 << Y_ADDR_W;

    // Sentinel meaning "no access"; this location is never stored.
    localparam logic [Y_ADDR_W-1:0] Y_IDLE_ADDR = 11'h7ff;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } y_state_t;

endpackage

// File: rtl/y_sram_array.sv
// Behavioural 1-write / 2-read synchronous Y store with registered read ports.
// Contents are not reset; the owning port zero-fills the array after reset.
module y_sram_array
    import y_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = Y_ADDR_W,
    parameter int unsigned DATA_W = Y_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reads return the pre-write contents; write-first behaviour is added by the port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data1 <= mem[rd_addr1];
        rd_data2 <= mem[rd_addr2];
    end

endmodule

// File: rtl/y_sram_port.sv
// Responder end of the Y SRAM bus: zero-fills the store after reset, then services
// two read ports and one write port with write-first forwarding on collisions.
module y_sram_port
    import y_sram_pkg::*;
#(
    parameter int unsigned          ADDR_W    = Y_ADDR_W,
    parameter int unsigned          DATA_W    = Y_DATA_W,
    parameter logic [ADDR_W-1:0]    IDLE_ADDR = Y_IDLE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_yReadAddress1,
    input  logic [ADDR_W-1:0] in_yReadAddress2,
    input  logic              in_yWriteEnable,
    input  logic [ADDR_W-1:0] in_yWriteAddress,
    input  logic [DATA_W-1:0] in_writeData,
    output logic [DATA_W-1:0] op_readData1,
    output logic [DATA_W-1:0] op_readData2,
    output logic              op_readValid1,
    output logic              op_readValid2,
    output logic              op_writeAck,
    output logic              op_ready
);

    localparam logic [ADDR_W-1:0] LAST_CLEAR = IDLE_ADDR - ADDR_W'(1);

    y_state_t          state;
    y_state_t          state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nx;

    logic              rd_svc1;
    logic              rd_svc2;
    logic              wr_commit;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata1;
    logic [DATA_W-1:0] arr_rdata2;

    logic              valid1_q;
    logic              valid2_q;
    logic              fwd1_q;
    logic              fwd2_q;
    logic              ack_q;
    logic [DATA_W-1:0] wdata_q;

    // State and clear-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // Next state, clear sequencing and request decode.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        rd_svc1    = 1'b0;
        rd_svc2    = 1'b0;
        wr_commit  = 1'b0;
        arr_we     = 1'b0;
        arr_waddr  = in_yWriteAddress;
        arr_wdata  = in_writeData;

        case (state)
            CLEAR: begin
                arr_we     = 1'b1;
                arr_waddr  = clr_cnt;
                arr_wdata  = '0;
                clr_cnt_nx = clr_cnt + ADDR_W'(1);
                if (clr_cnt == LAST_CLEAR) begin
                    clr_cnt_nx = '0;
                    state_nx   = RUN;
                end
            end
            RUN: begin
                rd_svc1   = (in_yReadAddress1 != IDLE_ADDR);
                rd_svc2   = (in_yReadAddress2 != IDLE_ADDR);
                wr_commit = in_yWriteEnable && (in_yWriteAddress != IDLE_ADDR);
                arr_we    = wr_commit;
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
    end

    y_sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .wr_en    (arr_we),
        .wr_addr  (arr_waddr),
        .wr_data  (arr_wdata),
        .rd_addr1 (in_yReadAddress1),
        .rd_addr2 (in_yReadAddress2),
        .rd_data1 (arr_rdata1),
        .rd_data2 (arr_rdata2)
    );

    // Valid, ack and collision-select registers; reset discards in-flight results.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            fwd1_q   <= 1'b0;
            fwd2_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            valid1_q <= rd_svc1;
            valid2_q <= rd_svc2;
            fwd1_q   <= rd_svc1 && wr_commit && (in_yReadAddress1 == in_yWriteAddress);
            fwd2_q   <= rd_svc2 && wr_commit && (in_yReadAddress2 == in_yWriteAddress);
            ack_q    <= wr_commit;
        end
    end

    // Write data held for forwarding to a colliding read in the following cycle.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            wdata_q <= in_writeData;
        end
    end

    assign op_readData1  = valid1_q ? (fwd1_q ? wdata_q : arr_rdata1) : '0;
    assign op_readData2  = valid2_q ? (fwd2_q ? wdata_q : arr_rdata2) : '0;
    assign op_readValid1 = valid1_q;
    assign op_readValid2 = valid2_q;
    assign op_writeAck   = ack_q;
    assign op_ready      = (state == RUN);

endmodule

// File: tb/tb_y_sram_port.sv
// Self-checking bench for y_sram_port: reference memory model plus a response
// scoreboard, covering clear timing, sentinel handling, collisions and reset.
module tb_y_sram_port;

    localparam int unsigned AW   = 11;
    localparam int unsigned DW   = 256;
    localparam logic [AW-1:0] IDLE = 11'h7ff;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] in_yReadAddress1;
    logic [AW-1:0] in_yReadAddress2;
    logic          in_yWriteEnable;
    logic [AW-1:0] in_yWriteAddress;
    logic [DW-1:0] in_writeData;
    logic [DW-1:0] op_readData1;
    logic [DW-1:0] op_readData2;
    logic          op_readValid1;
    logic          op_readValid2;
    logic          op_writeAck;
    logic          op_ready;

    typedef struct packed {
        logic          v1;
        logic [DW-1:0] d1;
        logic          v2;
        logic [DW-1:0] d2;
        logic          ack;
    } resp_t;

    resp_t         sb[$];
    logic [DW-1:0] model [2048];
    int            checks   = 0;
    int            failures = 0;

    y_sram_port dut (
        .clk              (clk),
        .reset            (reset),
        .in_yReadAddress1 (in_yReadAddress1),
        .in_yReadAddress2 (in_yReadAddress2),
        .in_yWriteEnable  (in_yWriteEnable),
        .in_yWriteAddress (in_yWriteAddress),
        .in_writeData     (in_writeData),
        .op_readData1     (op_readData1),
        .op_readData2     (op_readData2),
        .op_readValid1    (op_readValid1),
        .op_readValid2    (op_readValid2),
        .op_writeAck      (op_writeAck),
        .op_ready         (op_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        in_yReadAddress1 = IDLE;
        in_yReadAddress2 = IDLE;
        in_yWriteEnable  = 1'b0;
        in_yWriteAddress = IDLE;
        in_writeData     = '0;
    endtask

    // One RUN cycle: predict the response, drive, then compare after the edge.
    task automatic step(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        resp_t e;
        resp_t r;
        logic  commit;
        commit = we && (wa != IDLE);
        e.v1   = (a1 != IDLE);
        e.v2   = (a2 != IDLE);
        e.d1   = !e.v1 ? '0 : ((commit && wa == a1) ? wd : model[a1]);
        e.d2   = !e.v2 ? '0 : ((commit && wa == a2) ? wd : model[a2]);
        e.ack  = commit;
        if (commit) model[wa] = wd;
        sb.push_back(e);

        in_yReadAddress1 = a1;
        in_yReadAddress2 = a2;
        in_yWriteEnable  = we;
        in_yWriteAddress = wa;
        in_writeData     = wd;
        @(posedge clk);
        #1;
        r = sb.pop_front();
        check("valid1", DW'(op_readValid1), DW'(r.v1));
        check("data1",  op_readData1,       r.d1);
        check("valid2", DW'(op_readValid2), DW'(r.v2));
        check("data2",  op_readData2,       r.d2);
        check("ack",    DW'(op_writeAck),   DW'(r.ack));
        check("ready",  DW'(op_ready),      DW'(1'b1));
    endtask

    // Reset with live traffic on the inputs; none of it may surface.
    task automatic do_reset(input int cycles);
        reset            = 1'b1;
        in_yReadAddress1 = 11'h010;
        in_yReadAddress2 = 11'h020;
        in_yWriteEnable  = 1'b1;
        in_yWriteAddress = 11'h031;
        in_writeData     = DW'(1);
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        sb.delete();
        for (int i = 0; i < 2048; i++) model[i] = '0;
        check("rst_data1",  op_readData1,       '0);
        check("rst_data2",  op_readData2,       '0);
        check("rst_valid1", DW'(op_readValid1), '0);
        check("rst_valid2", DW'(op_readValid2), '0);
        check("rst_ack",    DW'(op_writeAck),   '0);
        check("rst_ready",  DW'(op_ready),      '0);
    endtask

    // Count the not-ready cycles after reset; optionally attempt a write mid-clear.
    task automatic wait_ready(input bit inject);
        int n;
        n = 1;
        while (op_ready !== 1'b1 && n < 3000) begin
            if (inject && n == 100) begin
                in_yWriteEnable  = 1'b1;
                in_yWriteAddress = 11'h005;
                in_writeData     = DW'(8'h77);
                in_yReadAddress1 = 11'h005;
            end else begin
                drive_idle();
            end
            @(posedge clk);
            #1;
            if (inject && n == 100) begin
                check("clear_ack",    DW'(op_writeAck),   '0);
                check("clear_valid1", DW'(op_readValid1), '0);
            end
            if (op_ready !== 1'b1) n++;
        end
        drive_idle();
        check("ready_low_cycles", DW'(n), DW'(2047));
        check("ready_up", DW'(op_ready), DW'(1'b1));
    endtask

    initial begin
        logic [DW-1:0] a5;
        a5 = {32{8'hA5}};
        drive_idle();
        do_reset(3);
        wait_ready(1'b1);

        // Cleared contents, including the location written during clear.
        step(11'h000, 11'h3ff, 1'b0, IDLE, '0);
        step(11'h7fe, 11'h005, 1'b0, IDLE, '0);

        // Write then read-back next cycle.
        step(IDLE, IDLE, 1'b1, 11'h010, a5);
        step(11'h010, IDLE, 1'b0, IDLE, '0);

        // Same-cycle collision on both ports.
        step(11'h020, 11'h020, 1'b1, 11'h020, DW'(16'h1234));

        // Sentinel read and sentinel write.
        step(11'h7fe, IDLE, 1'b1, IDLE, DW'(8'hFF));
        step(IDLE, 11'h7fe, 1'b0, IDLE, '0);

        // Random traffic over a small address set to force frequent collisions.
        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] r1, r2, w;
            logic [DW-1:0] d;
            r1 = ($urandom_range(0, 4) == 4) ? IDLE : AW'(11'h040 + $urandom_range(0, 3));
            r2 = ($urandom_range(0, 4) == 4) ? IDLE : AW'(11'h040 + $urandom_range(0, 3));
            w  = ($urandom_range(0, 4) == 4) ? IDLE : AW'(11'h040 + $urandom_range(0, 3));
            d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step(r1, r2, 1'($urandom_range(0, 1)), w, d);
        end

        // Reset mid-RUN wipes the store and restarts the clear.
        step(IDLE, IDLE, 1'b1, 11'h030, DW'(8'h55));
        do_reset(1);
        wait_ready(1'b0);
        step(11'h030, 11'h010, 1'b0, IDLE, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
